// File: rtl/block_sequencer.sv
// Sequences enabled functional blocks one at a time with a one-hot control line.
// Supports single-pass or looping operation, a per-block watchdog and abort.
module block_sequencer #(
    parameter int N_BLOCKS = 7,
    parameter int SEL_W    = 3,
    parameter int TMO_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                loop,
    input  logic [N_BLOCKS-1:0] blocks,
    input  logic [SEL_W-1:0]    selector,
    input  logic [N_BLOCKS-1:0] block_done,
    input  logic [TMO_W-1:0]    timeout_max,
    output logic [N_BLOCKS-1:0] control,
    output logic [SEL_W-1:0]    active_idx,
    output logic                busy,
    output logic                done,
    output logic                error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [SEL_W:0]   N_LIM = (SEL_W+1)'(N_BLOCKS);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_BLOCKS - 1);

    state_t              state;
    state_t              state_n;
    logic [N_BLOCKS-1:0] pending;
    logic [N_BLOCKS-1:0] pending_n;
    logic [SEL_W-1:0]    ptr;
    logic [SEL_W-1:0]    ptr_n;
    logic [SEL_W-1:0]    idx_q;
    logic [SEL_W-1:0]    idx_n;
    logic [TMO_W-1:0]    timer;
    logic [TMO_W-1:0]    timer_n;

    logic [N_BLOCKS-1:0] onehot;
    logic [SEL_W-1:0]    lo_idx;
    logic [SEL_W-1:0]    hi_idx;
    logic                hi_found;
    logic [SEL_W-1:0]    next_idx;
    logic                hit;
    logic                tmo_hit;
    logic                sel_bad;

    assign onehot  = N_BLOCKS'(1) << idx_q;
    assign hit     = |(block_done & onehot);
    assign tmo_hit = (timeout_max != '0) &&
                     (timer == timeout_max - TMO_W'(1));
    assign sel_bad = {1'b0, selector} >= N_LIM;

    // Wrapping search: lowest pending bit at or above ptr, else lowest overall.
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int i = N_BLOCKS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lo_idx = SEL_W'(i);
                if (SEL_W'(i) >= ptr) begin
                    hi_idx   = SEL_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        next_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_n   = state;
        pending_n = pending;
        ptr_n     = ptr;
        idx_n     = idx_q;
        timer_n   = timer;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (sel_bad) begin
                        idx_n   = selector;
                        state_n = S_ERROR;
                    end else begin
                        pending_n = blocks;
                        ptr_n     = selector;
                        state_n   = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (pending != '0) begin
                    idx_n   = next_idx;
                    timer_n = '0;
                    state_n = S_RUN;
                end else if (loop) begin
                    pending_n = blocks;
                    ptr_n     = '0;
                end else begin
                    state_n = S_DONE;
                end
            end
            S_RUN: begin
                if (hit) begin
                    pending_n = pending & ~onehot;
                    ptr_n     = (idx_q == LAST) ? '0
                                                : idx_q + SEL_W'(1);
                    state_n   = S_SCAN;
                end else if (tmo_hit) begin
                    state_n = S_ERROR;
                end else if (timer != '1) begin
                    timer_n = timer + TMO_W'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            S_ERROR: begin
                state_n = S_ERROR;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        // Abort overrides every transition except the idle hold.
        if (abort && state != S_IDLE) begin
            state_n   = S_IDLE;
            pending_n = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            pending <= '0;
            ptr     <= '0;
            idx_q   <= '0;
            timer   <= '0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            ptr     <= ptr_n;
            idx_q   <= idx_n;
            timer   <= timer_n;
        end
    end

    assign control    = (state == S_RUN) ? onehot : '0;
    assign active_idx = idx_q;
    assign busy       = (state == S_SCAN) || (state == S_RUN);
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERROR);

endmodule

// File: tb/tb_block_sequencer.sv
// Directed bench for block_sequencer: default 7-block build and a
// 16-block build driven from one linear stimulus sequence.
module tb_block_sequencer;

    logic       clk;
    logic       reset;
    logic       abort;
    logic       loop;

    logic       start;
    logic [6:0] blocks;
    logic [2:0] selector;
    logic [6:0] block_done;
    logic [7:0] timeout_max;
    logic [6:0] control;
    logic [2:0] active_idx;
    logic       busy;
    logic       done;
    logic       error;

    logic        start16;
    logic [15:0] blocks16;
    logic [3:0]  sel16;
    logic [15:0] bd16;
    logic [7:0]  tmo16;
    logic [15:0] ctl16;
    logic [3:0]  idx16;
    logic        busy16;
    logic        done16;
    logic        err16;

    int checks;
    int errors;

    block_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .loop(loop), .blocks(blocks), .selector(selector),
        .block_done(block_done), .timeout_max(timeout_max),
        .control(control), .active_idx(active_idx), .busy(busy),
        .done(done), .error(error)
    );

    block_sequencer #(.N_BLOCKS(16), .SEL_W(4), .TMO_W(8)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .abort(abort),
        .loop(loop), .blocks(blocks16), .selector(sel16),
        .block_done(bd16), .timeout_max(tmo16),
        .control(ctl16), .active_idx(idx16), .busy(busy16),
        .done(done16), .error(err16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hold a block for 4 RUN cycles, return done in the 4th, check the gap.
    task automatic serve(input string tag, input logic [6:0] exp);
        for (int i = 0; i < 3; i++) begin
            chk(tag, 32'(control), 32'(exp));
            tick();
        end
        chk(tag, 32'(control), 32'(exp));
        block_done = exp;
        tick();
        block_done = '0;
        chk({tag, "_gap"}, 32'(control), 0);
        chk({tag, "_busy"}, 32'(busy), 1);
        tick();
    endtask

    task automatic serve16(input string tag, input logic [15:0] exp);
        for (int i = 0; i < 3; i++) begin
            chk(tag, 32'(ctl16), 32'(exp));
            tick();
        end
        chk(tag, 32'(ctl16), 32'(exp));
        bd16 = exp;
        tick();
        bd16 = '0;
        chk({tag, "_gap"}, 32'(ctl16), 0);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        abort = 1'b0;
        loop = 1'b0;
        start = 1'b0;
        blocks = '0;
        selector = '0;
        block_done = '0;
        timeout_max = '0;
        start16 = 1'b0;
        blocks16 = '0;
        sel16 = '0;
        bd16 = '0;
        tmo16 = '0;
        tick();
        tick();
        chk("rst_control", 32'(control), 0);
        chk("rst_idx", 32'(active_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        reset = 1'b0;
        tick();

        // single pass, order 4,6,0,1
        blocks = 7'b1010011;
        selector = 3'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s1_scan_busy", 32'(busy), 1);
        chk("s1_scan_ctl", 32'(control), 0);
        tick();
        serve("s1_b4", 7'h10);
        serve("s1_b6", 7'h40);
        serve("s1_b0", 7'h01);
        serve("s1_b1", 7'h02);
        chk("s1_done", 32'(done), 1);
        chk("s1_done_busy", 32'(busy), 0);
        chk("s1_last_idx", 32'(active_idx), 1);
        tick();
        chk("s1_done_pulse", 32'(done), 0);
        chk("s1_idle_busy", 32'(busy), 0);
        tick();

        // wrap 6 -> 0
        blocks = 7'b1000001;
        selector = 3'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        serve("s2_b6", 7'h40);
        serve("s2_b0", 7'h01);
        chk("s2_done", 32'(done), 1);
        tick();

        // empty mask
        blocks = '0;
        selector = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s2e_c1_ctl", 32'(control), 0);
        chk("s2e_c1_done", 32'(done), 0);
        tick();
        chk("s2e_c2_done", 32'(done), 1);
        chk("s2e_c2_ctl", 32'(control), 0);
        tick();
        chk("s2e_c3_done", 32'(done), 0);

        // watchdog timeout
        timeout_max = 8'd5;
        blocks = 7'b0000100;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("s3_ctl_hold", 32'(control), 32'h04);
            tick();
        end
        chk("s3_error", 32'(error), 1);
        chk("s3_ctl_off", 32'(control), 0);
        chk("s3_idx", 32'(active_idx), 2);
        chk("s3_busy", 32'(busy), 0);
        tick();
        chk("s3_err_hold", 32'(error), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s3_abort_err", 32'(error), 0);
        chk("s3_abort_busy", 32'(busy), 0);
        tick();

        // done in the last RUN cycle before timeout wins
        blocks = 7'b0001100;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("s4_ctl", 32'(control), 32'h04);
            tick();
        end
        chk("s4_ctl5", 32'(control), 32'h04);
        block_done = 7'h04;
        tick();
        block_done = '0;
        chk("s4_no_err", 32'(error), 0);
        chk("s4_gap", 32'(control), 0);
        tick();
        chk("s4_next", 32'(control), 32'h08);
        block_done = 7'h08;
        tick();
        block_done = '0;
        tick();
        chk("s4_done", 32'(done), 1);
        chk("s4_done_err", 32'(error), 0);
        tick();

        // loop mode then abort
        timeout_max = '0;
        loop = 1'b1;
        blocks = 7'b0000011;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int r = 0; r < 2; r++) begin
            chk("s5_b0", 32'(control), 32'h01);
            block_done = 7'h01;
            tick();
            block_done = '0;
            chk("s5_gap0", 32'(control), 0);
            tick();
            chk("s5_b1", 32'(control), 32'h02);
            block_done = 7'h02;
            tick();
            block_done = '0;
            chk("s5_reload", 32'(control), 0);
            chk("s5_reload_busy", 32'(busy), 1);
            tick();
            chk("s5_scan", 32'(control), 0);
            tick();
        end
        chk("s5_b0_again", 32'(control), 32'h01);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s5_abort_ctl", 32'(control), 0);
        chk("s5_abort_busy", 32'(busy), 0);
        chk("s5_abort_done", 32'(done), 0);
        tick();
        chk("s5_abort_done2", 32'(done), 0);
        loop = 1'b0;

        // invalid selector
        blocks = 7'h7F;
        selector = 3'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s6_error", 32'(error), 1);
        chk("s6_idx", 32'(active_idx), 7);
        chk("s6_busy", 32'(busy), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s6_abort", 32'(error), 0);

        // async reset mid-RUN
        blocks = 7'h08;
        selector = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("s6_run", 32'(control), 32'h08);
        #1;
        reset = 1'b1;
        #1;
        chk("s6_rst_ctl", 32'(control), 0);
        chk("s6_rst_busy", 32'(busy), 0);
        chk("s6_rst_idx", 32'(active_idx), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("s6_post_ctl", 32'(control), 0);
        chk("s6_post_err", 32'(error), 0);

        // 16-block build, order 4,6,15,0,1
        blocks16 = 16'h8053;
        sel16 = 4'd4;
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        chk("p_scan_busy", 32'(busy16), 1);
        tick();
        serve16("p_b4", 16'h0010);
        serve16("p_b6", 16'h0040);
        serve16("p_b15", 16'h8000);
        serve16("p_b0", 16'h0001);
        serve16("p_b1", 16'h0002);
        chk("p_done", 32'(done16), 1);
        chk("p_idx", 32'(idx16), 1);
        tick();
        chk("p_done_pulse", 32'(done16), 0);
        chk("p_err", 32'(err16), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_sequencer.md
# block_sequencer

Parametrised control FSM that sequences a set of enabled functional blocks one at a time. It asserts a one-hot `control` line per block, waits for that block's completion handshake, and moves to the next enabled block with wrap-around from a selectable start index. It extends the fixed 7-block control FSM with:
- `N_BLOCKS` generalisation
- single-pass and loop modes
- a per-block watchdog timeout
- abort and error reporting

## Interface
- `N_BLOCKS`, 7: number of sequenced blocks (2..16).
- `SEL_W`, 3: width of `selector`; must satisfy 2^SEL_W >= `N_BLOCKS`.
- `TMO_W`, 8: width of the watchdog counter and `timeout_max`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sequence; sampled only in IDLE.
- `abort`  in  1  return to IDLE from any state; highest priority after reset.
- `loop`  in  1  0 = single pass, 1 = repeat until abort; sampled every SCAN.
- `blocks`  in  N_BLOCKS  enable mask; latched on start and on loop reload.
- `selector`  in  SEL_W  index of the first block to visit; latched on start.
- `block_done`  in  N_BLOCKS  per-block completion pulse/level; only the bit of the active block is observed.
- `timeout_max`  in  TMO_W  watchdog limit in RUN cycles; 0 disables.
- `control`  out  N_BLOCKS  one-hot enable of the active block; 0 outside RUN.
- `active_idx`  out  SEL_W  index of the current or last active block.
- `busy`  out  1  high in SCAN and RUN.
- `done`  out  1  one-cycle pulse in DONE.
- `error`  out  1  high in ERROR.

## Operation
Registers:
- `state`
- `pending[N_BLOCKS-1:0]`
- `ptr[SEL_W-1:0]`
- `active_idx`
- `timer[TMO_W-1:0]`

States and transitions:
- **IDLE**
  - `start`=1 and `selector` >= `N_BLOCKS`: go to ERROR; `active_idx`=`selector`.
  - `start`=1 otherwise: `pending`<=`blocks`, `ptr`<=`selector`, go to SCAN.
  - `start` outside IDLE is ignored.
- **SCAN** (exactly one cycle)
  - `pending`!=0: `active_idx`<=first set bit of `pending` searching upward from `ptr` with wrap at `N_BLOCKS`-1 to 0; `timer`<=0; go to RUN.
  - `pending`==0 and `loop`=0: go to DONE.
  - `pending`==0 and `loop`=1: `pending`<=`blocks`, `ptr`<=0, stay in SCAN.
  - If the reloaded `blocks` is also 0, the next SCAN with `loop`=1 reloads again. The FSM spins until `abort` or `loop`=0.
- **RUN**
  - `control` = 1<<`active_idx`.
  - `block_done[active_idx]`=1: clear `pending[active_idx]`; `ptr`<=`active_idx`+1, wrapping to 0 at `N_BLOCKS`; go to SCAN.
  - Else, if `timeout_max`!=0 and `timer`==`timeout_max`-1: go to ERROR.
  - Else `timer`<=`timer`+1, saturating at all-ones.
  - A done and a timeout in the same cycle resolve as done.
- **DONE**: `done`=1 for one cycle, then IDLE.
- **ERROR**: held until `abort`; `abort` returns the FSM to IDLE. `active_idx` keeps the offending index.
- **abort**: from SCAN, RUN, DONE or ERROR, go to IDLE next edge; `pending`<=0. `abort` in IDLE has no effect.
- **Reset values**: state IDLE; `control` 0; `active_idx` 0; `busy` 0; `done` 0; `error` 0; `pending` 0; `ptr` 0; `timer` 0.

## Timing
- All outputs decode from registers only. There is no combinational path from inputs to outputs.
- `start` sampled at edge E0 gives SCAN in cycle 1. `control` is valid from cycle 2 (start-to-control latency 2).
- `block_done` sampled at edge Ek: `control` is 0 in cycle k+1 (SCAN). The next block is enabled in cycle k+2, so there is always a one-cycle gap between blocks.
- Last done at Ek, single pass: DONE in cycle k+2 (`done`=1), IDLE in k+3.
- Timeout: `control` is high for exactly `timeout_max` cycles, then ERROR, with `control`=0 from the next cycle.
- Reset asserted mid-RUN drops `control` immediately, asynchronously. Release takes effect at the next `clk` edge.

## Test plan
- **Single pass, 7 blocks**: `blocks`=7'b1010011, `selector`=4, `loop`=0, each done returned 3 cycles after `control`.
  - `control` sequence is 0x10, 0x40, 0x01, 0x02.
  - `done` pulses once; `busy` drops afterwards.
- **Wrap and empty**:
  - `selector`=6, `blocks`=7'b1000001: visit order 6, 0.
  - `blocks`=0: `done` pulses at cycle 2 and `control` never asserts.
- **Timeout**: `timeout_max`=5, no `block_done`.
  - `control` is high for exactly 5 cycles, then `error`=1, `control`=0.
  - `abort` returns to IDLE and `error` drops.
- **Done at timeout boundary**: `block_done` arrives in the 5th RUN cycle with `timeout_max`=5. The sequence continues with no error.
- **Loop and abort**: `loop`=1, `blocks`=7'b0000011.
  - `control` cycles 0x01, 0x02, 0x01, ... indefinitely.
  - `abort` mid-RUN gives `control`=0 next cycle and no `done` pulse.
- **Invalid selector and reset**:
  - `selector`=7 with `N_BLOCKS`=7 gives ERROR with `active_idx`=7.
  - `reset` asserted mid-RUN clears all outputs asynchronously.
- **Parameter sweep**: repeat the first scenario with `N_BLOCKS`=16, `SEL_W`=4.
